// File: rtl/m68k_bus_responder_if.sv
// m68k_bus_responder_if
// Bundles the 68000 local-bus signals seen by the bus-cycle responder.
//   AS_L, UDS_L, LDS_L          : CPU address / data strobes (active low)
//   *Select_H                   : address-decoder region selects (active high)
//   DramDtack_L, CanBusDtack_L  : acknowledges from the DRAM and CAN controllers
//   DTACK_L, BERR_L             : acknowledge / bus error returned to the CPU
//   CycleActive_H               : responder is busy with a bus cycle
// Modports:
//   master : the CPU/decoder side that drives strobes and selects
//   slave  : the responder that returns DTACK_L / BERR_L
interface m68k_bus_responder_if;
    logic AS_L;
    logic UDS_L;
    logic LDS_L;
    logic OnChipRomSelect_H;
    logic OnChipRamSelect_H;
    logic IOSelect_H;
    logic DramSelect_H;
    logic CanBusSelect_H;
    logic DramDtack_L;
    logic CanBusDtack_L;
    logic DTACK_L;
    logic BERR_L;
    logic CycleActive_H;

    modport master (
        output AS_L, UDS_L, LDS_L,
        output OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
        output DramSelect_H, CanBusSelect_H,
        output DramDtack_L, CanBusDtack_L,
        input  DTACK_L, BERR_L, CycleActive_H
    );

    modport slave (
        input  AS_L, UDS_L, LDS_L,
        input  OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
        input  DramSelect_H, CanBusSelect_H,
        input  DramDtack_L, CanBusDtack_L,
        output DTACK_L, BERR_L, CycleActive_H
    );
endinterface

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
// Answers each 68000 bus cycle with DTACK_L after a per-region wait count
// (ROM/RAM/IO), or by forwarding the DRAM / CAN controller acknowledge.
// A cycle that gets no acknowledge within TIMEOUT_CYCLES clocks is
// terminated with BERR_L, which also covers unmapped addresses.
// Ports:
//   Clock   : system clock, rising edge
//   Reset_H : synchronous active-high reset
//   bus     : slave side of m68k_bus_responder_if (strobes, selects,
//             external acknowledges in; DTACK_L, BERR_L, CycleActive_H out)
// All outputs come straight from flops.
module m68k_bus_responder #(
    parameter int ROM_WAIT       = 1,
    parameter int RAM_WAIT       = 1,
    parameter int IO_WAIT        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   Clock,
    input  logic                   Reset_H,
    m68k_bus_responder_if.slave    bus
);

    localparam logic [7:0]  ROM_W   = 8'(ROM_WAIT);
    localparam logic [7:0]  RAM_W   = 8'(RAM_WAIT);
    localparam logic [7:0]  IO_W    = 8'(IO_WAIT);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RECOVER = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ACK     = 3'd3,
        ST_BERR    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        RG_NONE = 3'd0,
        RG_ROM  = 3'd1,
        RG_RAM  = 3'd2,
        RG_IO   = 3'd3,
        RG_DRAM = 3'd4,
        RG_CAN  = 3'd5
    } region_t;

    state_t      state_r;
    region_t     region_r;
    logic [7:0]  wait_cnt_r;
    logic [15:0] to_cnt_r;
    logic        dtack_l_r;
    logic        berr_l_r;
    logic        active_r;

    logic        cycle_start_s;
    region_t     sel_region_s;
    logic [7:0]  sel_wait_s;
    logic        ack_cond_s;
    logic        timeout_s;

    assign cycle_start_s = !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);
    assign timeout_s     = (to_cnt_r == TO_LAST);

    // Priority encode the decoder selects: ROM > RAM > IO > DRAM > CAN.
    always_comb begin
        sel_region_s = RG_NONE;
        if (bus.OnChipRomSelect_H) begin
            sel_region_s = RG_ROM;
        end else if (bus.OnChipRamSelect_H) begin
            sel_region_s = RG_RAM;
        end else if (bus.IOSelect_H) begin
            sel_region_s = RG_IO;
        end else if (bus.DramSelect_H) begin
            sel_region_s = RG_DRAM;
        end else if (bus.CanBusSelect_H) begin
            sel_region_s = RG_CAN;
        end else begin
            sel_region_s = RG_NONE;
        end
    end

    // Wait count loaded at cycle start; externally acknowledged regions load 0.
    always_comb begin
        sel_wait_s = 8'd0;
        case (sel_region_s)
            RG_ROM:  sel_wait_s = ROM_W;
            RG_RAM:  sel_wait_s = RAM_W;
            RG_IO:   sel_wait_s = IO_W;
            default: sel_wait_s = 8'd0;
        endcase
    end

    // Acknowledge condition for the region latched at cycle start.
    always_comb begin
        ack_cond_s = 1'b0;
        case (region_r)
            RG_ROM, RG_RAM, RG_IO: ack_cond_s = (wait_cnt_r == 8'd0);
            RG_DRAM:               ack_cond_s = !bus.DramDtack_L;
            RG_CAN:                ack_cond_s = !bus.CanBusDtack_L;
            default:               ack_cond_s = 1'b0;
        endcase
    end

    // Bus-cycle state machine with registered DTACK_L / BERR_L / CycleActive_H.
    // In WAIT the order of tests gives abort over acknowledge over timeout.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_r    <= ST_RECOVER;
            region_r   <= RG_NONE;
            wait_cnt_r <= 8'd0;
            to_cnt_r   <= 16'd0;
            dtack_l_r  <= 1'b1;
            berr_l_r   <= 1'b1;
            active_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RECOVER: begin
                    // A strobe left low across reset must not start a cycle.
                    if (bus.AS_L) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (cycle_start_s) begin
                        state_r    <= ST_WAIT;
                        region_r   <= sel_region_s;
                        wait_cnt_r <= sel_wait_s;
                        to_cnt_r   <= 16'd0;
                        active_r   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.AS_L) begin
                        state_r  <= ST_IDLE;
                        active_r <= 1'b0;
                    end else if (ack_cond_s) begin
                        state_r   <= ST_ACK;
                        dtack_l_r <= 1'b0;
                    end else if (timeout_s) begin
                        state_r  <= ST_BERR;
                        berr_l_r <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                        if (wait_cnt_r != 8'd0) begin
                            wait_cnt_r <= wait_cnt_r - 8'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.AS_L) begin
                        state_r   <= ST_IDLE;
                        dtack_l_r <= 1'b1;
                        active_r  <= 1'b0;
                    end
                end
                ST_BERR: begin
                    if (bus.AS_L) begin
                        state_r  <= ST_IDLE;
                        berr_l_r <= 1'b1;
                        active_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_RECOVER;
                    dtack_l_r <= 1'b1;
                    berr_l_r  <= 1'b1;
                    active_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DTACK_L       = dtack_l_r;
    assign bus.BERR_L        = berr_l_r;
    assign bus.CycleActive_H = active_r;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder
// Scoreboard bench for m68k_bus_responder. Two instances share strobes and
// selects but have separate AS_L: dut_a (ROM 1, RAM 1, IO 3, timeout 16)
// and dut_b (IO 0, timeout 16). Every change of {DTACK_L, BERR_L,
// CycleActive_H} on either instance is popped against a queue of expected
// (edge number, value) entries written by the stimulus.
module tb_m68k_bus_responder;

    typedef struct {
        int         cyc;
        logic [2:0] val;   // {DTACK_L, BERR_L, CycleActive_H}
    } exp_t;

    localparam logic [2:0] V_IDLE = 3'b110;
    localparam logic [2:0] V_BUSY = 3'b111;
    localparam logic [2:0] V_ACK  = 3'b011;
    localparam logic [2:0] V_BERR = 3'b101;

    logic Clock;
    logic Reset_H;
    logic as_a, as_b, uds, lds;
    logic sel_rom, sel_ram, sel_io, sel_dram, sel_can;
    logic dram_l, can_l;

    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;
    logic [2:0] prev_a, prev_b;
    exp_t exp_a[$];
    exp_t exp_b[$];

    m68k_bus_responder_if bus_a ();
    m68k_bus_responder_if bus_b ();

    assign bus_a.AS_L = as_a;
    assign bus_b.AS_L = as_b;
    assign bus_a.UDS_L = uds;
    assign bus_b.UDS_L = uds;
    assign bus_a.LDS_L = lds;
    assign bus_b.LDS_L = lds;
    assign bus_a.OnChipRomSelect_H = sel_rom;
    assign bus_b.OnChipRomSelect_H = sel_rom;
    assign bus_a.OnChipRamSelect_H = sel_ram;
    assign bus_b.OnChipRamSelect_H = sel_ram;
    assign bus_a.IOSelect_H = sel_io;
    assign bus_b.IOSelect_H = sel_io;
    assign bus_a.DramSelect_H = sel_dram;
    assign bus_b.DramSelect_H = sel_dram;
    assign bus_a.CanBusSelect_H = sel_can;
    assign bus_b.CanBusSelect_H = sel_can;
    assign bus_a.DramDtack_L = dram_l;
    assign bus_b.DramDtack_L = dram_l;
    assign bus_a.CanBusDtack_L = can_l;
    assign bus_b.CanBusDtack_L = can_l;

    m68k_bus_responder #(
        .ROM_WAIT(1), .RAM_WAIT(1), .IO_WAIT(3), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .Clock(Clock), .Reset_H(Reset_H), .bus(bus_a.slave)
    );

    m68k_bus_responder #(
        .ROM_WAIT(1), .RAM_WAIT(1), .IO_WAIT(0), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .Clock(Clock), .Reset_H(Reset_H), .bus(bus_b.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Edge counter: after posedge number n, cyc == n.
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic push_exp(input int which, input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        if (which == 0) exp_a.push_back(e);
        else            exp_b.push_back(e);
    endtask

    task automatic observe(input int which, input logic [2:0] cur);
        exp_t e;
        bit   have;
        have = 1'b0;
        checks++;
        if (which == 0 && exp_a.size() > 0) begin
            e = exp_a.pop_front();
            have = 1'b1;
        end else if (which == 1 && exp_b.size() > 0) begin
            e = exp_b.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            errors++;
            $display("FAIL unexpected_change dut=%0d edge=%0d got=%b required no change",
                     which, cyc, cur);
        end else if (e.cyc != cyc || e.val !== cur) begin
            errors++;
            $display("FAIL output_change dut=%0d got edge=%0d val=%b required edge=%0d val=%b",
                     which, cyc, cur, e.cyc, e.val);
        end
    endtask

    // Monitor: compare every change of the output triple against the queues.
    always @(negedge Clock) begin
        logic [2:0] cur_a, cur_b;
        if (mon_en) begin
            cur_a = {bus_a.DTACK_L, bus_a.BERR_L, bus_a.CycleActive_H};
            cur_b = {bus_b.DTACK_L, bus_b.BERR_L, bus_b.CycleActive_H};
            if (cur_a !== prev_a) begin
                observe(0, cur_a);
                prev_a = cur_a;
            end
            if (cur_b !== prev_b) begin
                observe(1, cur_b);
                prev_b = cur_b;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    // Called at a negedge: the next posedge is e0.
    task automatic start_cycle(input int which, output int e0);
        if (which == 0) as_a = 1'b0;
        else            as_b = 1'b0;
        uds = 1'b0;
        e0 = cyc + 1;
        push_exp(which, e0, V_BUSY);
    endtask

    // Called at a negedge while the DUT sits in ACK or BERR.
    task automatic end_cycle(input int which);
        if (which == 0) as_a = 1'b1;
        else            as_b = 1'b1;
        uds = 1'b1;
        lds = 1'b1;
        {sel_rom, sel_ram, sel_io, sel_dram, sel_can} = 5'b00000;
        dram_l = 1'b1;
        push_exp(which, cyc + 1, V_IDLE);
        repeat (2) @(negedge Clock);
    endtask

    task automatic check_now(input string name, input logic [2:0] got, input logic [2:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    initial begin
        int e0;
        cyc = 0; checks = 0; errors = 0; mon_en = 1'b0;
        prev_a = V_IDLE; prev_b = V_IDLE;
        Reset_H = 1'b1;
        as_a = 1'b1; as_b = 1'b1; uds = 1'b1; lds = 1'b1;
        {sel_rom, sel_ram, sel_io, sel_dram, sel_can} = 5'b00000;
        dram_l = 1'b1; can_l = 1'b1;

        repeat (3) @(negedge Clock);
        check_now("reset_a", {bus_a.DTACK_L, bus_a.BERR_L, bus_a.CycleActive_H}, V_IDLE);
        check_now("reset_b", {bus_b.DTACK_L, bus_b.BERR_L, bus_b.CycleActive_H}, V_IDLE);
        Reset_H = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge Clock);

        // ROM read, ROM_WAIT=1: DTACK_L low at e0+2.
        sel_rom = 1'b1;
        start_cycle(0, e0);
        push_exp(0, e0 + 2, V_ACK);
        wait_until(e0 + 4);
        end_cycle(0);

        // IO write, IO_WAIT=3: DTACK_L low at e0+4.
        sel_io = 1'b1;
        start_cycle(0, e0);
        uds = 1'b1; lds = 1'b0;
        push_exp(0, e0 + 4, V_ACK);
        wait_until(e0 + 6);
        end_cycle(0);

        // IO write, IO_WAIT=0: DTACK_L low at e0+1.
        sel_io = 1'b1;
        start_cycle(1, e0);
        uds = 1'b1; lds = 1'b0;
        push_exp(1, e0 + 1, V_ACK);
        wait_until(e0 + 3);
        end_cycle(1);

        // DRAM: acknowledge driven low after edge e0+5, sampled at e0+6.
        sel_dram = 1'b1;
        start_cycle(0, e0);
        push_exp(0, e0 + 6, V_ACK);
        wait_until(e0 + 5);
        dram_l = 1'b0;
        wait_until(e0 + 8);
        end_cycle(0);

        // CAN: acknowledge already low at e0 gives DTACK_L at e0+1.
        sel_can = 1'b1;
        can_l = 1'b0;
        start_cycle(0, e0);
        push_exp(0, e0 + 1, V_ACK);
        wait_until(e0 + 3);
        can_l = 1'b1;
        end_cycle(0);

        // Unmapped: BERR_L low at e0+16, released when AS_L rises.
        start_cycle(0, e0);
        push_exp(0, e0 + 16, V_BERR);
        wait_until(e0 + 19);
        end_cycle(0);

        // ROM and IO both selected: ROM timing; later select changes ignored.
        sel_rom = 1'b1; sel_io = 1'b1;
        start_cycle(0, e0);
        push_exp(0, e0 + 2, V_ACK);
        @(negedge Clock);
        sel_rom = 1'b0; sel_dram = 1'b1; dram_l = 1'b1;
        wait_until(e0 + 5);
        end_cycle(0);

        // Abort during IO WAIT: AS_L high sampled at e0+2, no DTACK or BERR.
        sel_io = 1'b1;
        start_cycle(0, e0);
        wait_until(e0 + 1);
        as_a = 1'b1; uds = 1'b1;
        push_exp(0, e0 + 2, V_IDLE);
        wait_until(e0 + 22);
        sel_io = 1'b0;

        // Reset while DTACK_L low with AS_L still low.
        sel_rom = 1'b1;
        start_cycle(0, e0);
        push_exp(0, e0 + 2, V_ACK);
        wait_until(e0 + 3);
        Reset_H = 1'b1;
        push_exp(0, e0 + 4, V_IDLE);
        @(negedge Clock);
        Reset_H = 1'b0;
        wait_until(e0 + 10);
        as_a = 1'b1; uds = 1'b1;
        repeat (2) @(negedge Clock);

        // Fresh cycle after AS_L has been seen high.
        start_cycle(0, e0);
        push_exp(0, e0 + 2, V_ACK);
        wait_until(e0 + 3);
        end_cycle(0);

        repeat (3) @(negedge Clock);
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL pending_a got=%0d required=0 outstanding expectations", exp_a.size());
        end
        checks++;
        if (exp_b.size() != 0) begin
            errors++;
            $display("FAIL pending_b got=%0d required=0 outstanding expectations", exp_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
